ps2_dev_tx: RTL and testbench

PS2_DEV_TX -- requirements
Module: ps2_dev_tx

---
 rtl/ps2_dev_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_dev_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - PS/2 device-to-host byte transmitter with byte FIFO and host inhibit handling
module ps2_dev_tx #(
    parameter int CLK_HALF   = 1120,
    parameter int GAP_CYC    = 2800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       host_rq
);

    localparam int TMAX = (CLK_HALF > GAP_CYC) ? CLK_HALF : GAP_CYC;
    localparam int TW   = $clog2(TMAX);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP,
        S_INHIBIT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    idx_q, idx_d;

    logic [1:0] clk_sync, dat_sync;
    logic       sclk, sdat;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push, pop, empty;
    logic [7:0]    head;
    logic          frame_bit;

    // Line synchronizers idle high so a reset never looks like an inhibit
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
        end
    end

    assign sclk = clk_sync[1];
    assign sdat = dat_sync[1];

    assign empty    = (count == '0);
    assign tx_ready = (count != FULL_CNT);
    assign push     = tx_valid & tx_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk28) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Line level for the current bit: start, eight data LSB first, odd parity, stop
    always_comb begin
        frame_bit = 1'b1;
        case (idx_q)
            4'd0:    frame_bit = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:
                     frame_bit = head[3'(idx_q[2:0] - 3'd1)];
            4'd9:    frame_bit = ~^head;
            default: frame_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        pop        = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!empty && sclk && sdat) begin
                    state_d = S_HIGH;
                    idx_d   = '0;
                end
            end
            S_HIGH: begin
                ps2_dat_oe = ~frame_bit;
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    // Host holding the clock low at the end of the high phase aborts the frame
                    state_d = sclk ? S_LOW : S_INHIBIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LOW: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = ~frame_bit;
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (idx_q == 4'd10) begin
                        state_d = S_GAP;
                        idx_d   = '0;
                        pop     = ~empty;
                    end else begin
                        state_d = S_HIGH;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_INHIBIT: begin
                if (!sclk) begin
                    timer_d = '0;
                end else if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == S_HIGH) || (state_q == S_LOW);
    assign host_rq = (state_q == S_IDLE) && sclk && !sdat;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - scoreboard bench for ps2_dev_tx with a byte-level line model
module tb_ps2_dev_tx;

    localparam int CH  = 20;
    localparam int GAP = 60;
    localparam int FD  = 4;
    localparam int FRAME_CYC = 22 * CH;

    logic       clk28 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_i, ps2_dat_i;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, host_rq;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [7:0]  exp_q [$];
    int          mon_nbits = 0;
    logic [10:0] bits_v = '0;
    logic [10:0] last_frame = '0;
    int          frames_done = 0;
    int          frames_started = 0;
    int          aborted = 0;
    int          busy_cnt = 0;
    int          idle_cnt = 0;
    bit          gap_valid = 1'b0;
    logic        clk_oe_prev = 1'b0;
    logic        busy_prev = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | host_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | host_dat_low);

    ps2_dev_tx #(.CLK_HALF(CH), .GAP_CYC(GAP), .FIFO_DEPTH(FD)) dut (
        .clk28(clk28), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy), .host_rq(host_rq)
    );

    always #5 clk28 = ~clk28;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Expected line levels at the 11 device clock falls, index 0 = start bit
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    // Monitor: collects bits at device clock falls, scores whole frames against the queue
    always @(negedge clk28) begin
        if (rst) begin
            exp_q.delete();
            mon_nbits = 0;
            busy_cnt = 0;
            idle_cnt = 0;
            gap_valid = 1'b0;
            clk_oe_prev = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (ps2_clk_oe && !clk_oe_prev && mon_nbits < 11) begin
                bits_v[mon_nbits] = ps2_dat_i;
                mon_nbits++;
            end
            if (busy && !busy_prev) begin
                frames_started++;
                if (gap_valid) chk(idle_cnt >= GAP, "idle_gap", idle_cnt, GAP);
                idle_cnt = 0;
            end
            if (busy) busy_cnt++;
            else idle_cnt++;
            if (!busy && busy_prev) begin
                if (mon_nbits == 11) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_frame", int'(bits_v), 0);
                    end else begin
                        logic [10:0] e;
                        e = frame_of(exp_q.pop_front());
                        chk(bits_v == e, "frame_bits", int'(bits_v), int'(e));
                    end
                    chk(busy_cnt == FRAME_CYC, "busy_len", busy_cnt, FRAME_CYC);
                    last_frame = bits_v;
                    frames_done++;
                end else begin
                    aborted++;
                end
                gap_valid = 1'b1;
                mon_nbits = 0;
                busy_cnt = 0;
                idle_cnt = 1;
            end
            clk_oe_prev = ps2_clk_oe;
            busy_prev = busy;
        end
    end

    // Called at a negedge; leaves tx_valid high so callers can stream bytes
    task automatic send(input logic [7:0] b, output logic busy_at_acc);
        int n = 0;
        tx_data = b;
        tx_valid = 1'b1;
        busy_at_acc = 1'b0;
        while (!tx_ready && n < 5000) begin
            @(negedge clk28);
            n++;
        end
        if (!tx_ready) begin
            chk(1'b0, "send_timeout", n, 5000);
        end else begin
            busy_at_acc = busy;
            @(posedge clk28);
            exp_q.push_back(b);
            @(negedge clk28);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin
            @(negedge clk28);
            n++;
        end
        chk(exp_q.size() == 0 && !busy, "drain", exp_q.size(), 0);
        repeat (GAP + 5) @(negedge clk28);
    endtask

    task automatic wait_bits(input int nb);
        int n = 0;
        while (mon_nbits < nb && n < 5000) begin
            @(negedge clk28);
            n++;
        end
        chk(mon_nbits >= nb, "wait_bits", mon_nbits, nb);
    endtask

    initial begin
        logic ba;
        int n;
        int ab0, fs0;
        bit seen;

        #1;
        chk(tx_ready == 1'b1, "rst_tx_ready", int'(tx_ready), 1);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b0, "rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        chk(host_rq == 1'b0, "rst_host_rq", int'(host_rq), 0);
        repeat (3) @(negedge clk28);
        rst = 1'b0;
        @(negedge clk28);

        // Single 0x1C frame
        send(8'h1C, ba);
        tx_valid = 1'b0;
        drain();
        chk(last_frame == 11'b10000111000, "frame_1c", int'(last_frame), 11'b10000111000);

        // Back-to-back 0x00, 0xFF
        send(8'h00, ba);
        send(8'hFF, ba);
        tx_valid = 1'b0;
        drain();
        chk(last_frame[9] == 1'b1, "parity_ff", int'(last_frame[9]), 1);

        // Five bytes with tx_valid held: FIFO fills while first frame sends
        n = frames_done;
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i), ba);
        chk(tx_ready == 1'b0 && busy == 1'b1, "fifo_full", int'({tx_ready, busy}), 1);
        send(8'h34, ba);
        tx_valid = 1'b0;
        chk(ba == 1'b0, "fifth_after_pop", int'(ba), 0);
        drain();
        chk(frames_done == n + 5, "five_frames", frames_done - n, 5);

        // Host inhibit during bit 4 of 0xA5
        ab0 = aborted;
        n = frames_done;
        send(8'hA5, ba);
        tx_valid = 1'b0;
        wait_bits(4);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            @(negedge clk28);
            n++;
        end
        host_clk_low = 1'b1;
        repeat (2 * CH) @(negedge clk28);
        chk(!busy && !ps2_clk_oe && !ps2_dat_oe, "inhibit_release",
            int'({busy, ps2_clk_oe, ps2_dat_oe}), 0);
        chk(aborted == ab0 + 1, "inhibit_abort", aborted - ab0, 1);
        repeat (CH) @(negedge clk28);
        host_clk_low = 1'b0;
        n = 0;
        while (!busy && n < 3 * GAP) begin
            @(negedge clk28);
            n++;
        end
        chk(n >= GAP && n <= GAP + 6, "inhibit_gap", n, GAP);
        drain();
        chk(last_frame == frame_of(8'hA5), "resend_a5", int'(last_frame), int'(frame_of(8'hA5)));

        // Host request-to-send blocks frame start
        host_dat_low = 1'b1;
        repeat (10) @(negedge clk28);
        chk(host_rq == 1'b1, "host_rq_set", int'(host_rq), 1);
        send(8'h5A, ba);
        tx_valid = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk28);
            if (busy) seen = 1'b1;
        end
        chk(!seen && host_rq, "host_rq_block", int'({seen, host_rq}), 1);
        host_dat_low = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk28);
            n++;
        end
        chk(n <= 3 && busy, "rq_release_start", n, 3);
        drain();

        // Randomized bytes with random spacing
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), ba);
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 400)) @(negedge clk28);
        end
        drain();

        // Reset at bit 6 of a frame with a second byte queued
        send(8'($urandom_range(0, 255)), ba);
        send(8'($urandom_range(0, 255)), ba);
        tx_valid = 1'b0;
        wait_bits(6);
        @(posedge clk28);
        #2 rst = 1'b1;
        #1;
        chk(!ps2_clk_oe && !ps2_dat_oe, "rst_mid_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        chk(tx_ready && !busy, "rst_mid_state", int'({tx_ready, busy}), 2);
        repeat (2) @(negedge clk28);
        rst = 1'b0;
        fs0 = frames_started;
        repeat (3 * FRAME_CYC + GAP) @(negedge clk28);
        chk(frames_started == fs0, "no_frames_after_rst", frames_started - fs0, 0);
        chk(tx_ready == 1'b1, "ready_after_rst", int'(tx_ready), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
